// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Decode-stage immediate generator. It pulls the immediate straight out of the
// raw 32-bit instruction word, sign-extends it to XLEN and registers it. The
// registered result sits behind a valid/ready handshake with a 2-entry skid
// buffer, so ready_o never depends combinationally on ready_i.
//
// Parameters
//   XLEN    : output immediate width (32 or 64)
//   TAG_W   : width of the sideband tag (usually the PC) that travels with
//             the immediate
//   ZIMM_EN : 1 = csr_zimm_i selects the zero-extended CSR zimm field,
//             0 = csr_zimm_i is ignored
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   valid_i    : upstream beat valid
//   ready_o    : block can accept a beat (low only while the skid is occupied)
//   instr_i    : raw instruction word
//   ImmSel_i   : immediate format select (R/I/S/B/U/J)
//   csr_zimm_i : pick instr[19:15] zero-extended instead of ImmSel_i
//   tag_i      : sideband tag for the incoming beat
//   flush_i    : synchronous flush, drops every held and incoming beat
//   valid_o    : output beat valid
//   ready_i    : downstream accepts the output beat
//   imm_o      : selected, extended immediate
//   tag_o      : tag belonging to imm_o
//   err_o      : sticky flag, an accepted beat had an undefined ImmSel_i
// -----------------------------------------------------------------------------

package imm_gen_pipe_pkg;

    // Immediate format encodings. The 3-bit field leaves 3'd6 and 3'd7
    // undefined; accepting either of those raises the sticky error flag.
    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_sel_e;

endpackage

module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 32,
    parameter int ZIMM_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      instr_i,
    input  imm_sel_e         ImmSel_i,
    input  logic             csr_zimm_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             err_o
);

    // The opcode bits never feed any immediate format.
    logic unused_opcode;
    assign unused_opcode = &{1'b0, instr_i[6:0]};

    // -------------------------------------------------------------------------
    // Immediate extraction.
    // Every signed format starts from a word filled with the sign bit
    // (instr[31]) and then overwrites only the low bits that the format
    // defines. This gives correct sign extension for both XLEN=32 and
    // XLEN=64 without any zero-width replication when XLEN=32.
    // The zimm path overrides the format select and is not an error source.
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] imm_next;
    logic            sel_illegal;

    always_comb begin
        imm_next    = '0;
        sel_illegal = 1'b0;
        if ((ZIMM_EN != 0) && csr_zimm_i) begin
            imm_next[4:0] = instr_i[19:15];
        end else begin
            case (ImmSel_i)
                IMM_I: begin
                    imm_next       = {XLEN{instr_i[31]}};
                    imm_next[11:0] = instr_i[31:20];
                end
                IMM_S: begin
                    imm_next       = {XLEN{instr_i[31]}};
                    imm_next[11:0] = {instr_i[31:25], instr_i[11:7]};
                end
                IMM_B: begin
                    imm_next       = {XLEN{instr_i[31]}};
                    imm_next[12:0] = {instr_i[31], instr_i[7], instr_i[30:25],
                                      instr_i[11:8], 1'b0};
                end
                IMM_U: begin
                    imm_next       = {XLEN{instr_i[31]}};
                    imm_next[31:0] = {instr_i[31:12], 12'b0};
                end
                IMM_J: begin
                    imm_next       = {XLEN{instr_i[31]}};
                    imm_next[20:0] = {instr_i[31], instr_i[19:12], instr_i[20],
                                      instr_i[30:21], 1'b0};
                end
                IMM_R: begin
                    imm_next = '0;
                end
                default: begin
                    imm_next    = '0;
                    sel_illegal = 1'b1;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Handshake decode.
    // ready_o comes only from the skid valid bit, so downstream ready never
    // ripples upstream in the same cycle. A beat presented during a flush
    // is not kept, so it is excluded from in_accept (which also gates the
    // error flag).
    // -------------------------------------------------------------------------
    logic            main_valid;
    logic [XLEN-1:0] main_imm;
    logic [TAG_W-1:0] main_tag;
    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic            err_q;

    logic in_accept;
    logic main_free;

    assign ready_o   = ~skid_valid;
    assign in_accept = valid_i & ready_o & ~flush_i;
    // Main can take new data if it is empty or its beat leaves this cycle.
    assign main_free = ~main_valid | ready_i;

    // -------------------------------------------------------------------------
    // Main/skid storage.
    // When main frees up, the skid entry (older) always wins over the
    // incoming beat; the incoming beat cannot collide with it because
    // ready_o is low whenever the skid is occupied. When main is stuck, a
    // new beat parks in the skid and ready_o drops on the next cycle.
    // Flush only clears the valid bits; data fields may keep stale values.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_imm   <= '0;
            main_tag   <= '0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_tag   <= '0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_imm   <= skid_imm;
                main_tag   <= skid_tag;
                skid_valid <= 1'b0;
            end else if (in_accept) begin
                main_valid <= 1'b1;
                main_imm   <= imm_next;
                main_tag   <= tag_i;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_accept) begin
            skid_valid <= 1'b1;
            skid_imm   <= imm_next;
            skid_tag   <= tag_i;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky illegal-select flag. Only reset clears it; flush leaves it set
    // so software or a debug unit can still see it afterwards.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (in_accept && sel_illegal) begin
            err_q <= 1'b1;
        end
    end

    assign valid_o = main_valid;
    assign imm_o   = main_imm;
    assign tag_o   = main_tag;
    assign err_o   = err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Testbench for imm_gen_pipe. Two instances share every input: one with
// XLEN=32 and one with XLEN=64. Expected beats go into a scoreboard queue
// when the handshake accepts them and are compared when the output handshake
// fires. A vector table covers the immediate formats; hand-written sequences
// cover backpressure, flush, the error flag and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;
    import imm_gen_pipe_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [31:0] instr_i;
    imm_sel_e    sel_i;
    logic        csr_zimm_i;
    logic [31:0] tag_i;
    logic        flush_i;
    logic        ready_i;

    logic        ready_o32, valid_o32, err_o32;
    logic [31:0] imm_o32, tag_o32;
    logic        ready_o64, valid_o64, err_o64;
    logic [63:0] imm_o64;
    logic [31:0] tag_o64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ZIMM_EN(1)) dut32 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o32),
        .instr_i(instr_i), .ImmSel_i(sel_i), .csr_zimm_i(csr_zimm_i),
        .tag_i(tag_i), .flush_i(flush_i), .valid_o(valid_o32),
        .ready_i(ready_i), .imm_o(imm_o32), .tag_o(tag_o32), .err_o(err_o32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .ZIMM_EN(1)) dut64 (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o64),
        .instr_i(instr_i), .ImmSel_i(sel_i), .csr_zimm_i(csr_zimm_i),
        .tag_i(tag_i), .flush_i(flush_i), .valid_o(valid_o64),
        .ready_i(ready_i), .imm_o(imm_o64), .tag_o(tag_o64), .err_o(err_o64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp32;
        logic [63:0] exp64;
        logic [31:0] tag;
    } exp_t;

    typedef struct {
        imm_sel_e    sel;
        logic [31:0] instr;
        logic        zimm;
        logic [31:0] exp32;
        logic [63:0] exp64;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    vec_t vectors[9];
    int   total_checks;
    int   passed_checks;
    bit   last_in_fire;

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total_checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        else
            passed_checks++;
    endtask

    // Runs one clock with the inputs already applied. Handshakes are
    // evaluated before the edge; outputs are looked at #1 after it.
    task automatic cycle();
        bit   out_fire;
        exp_t e;
        out_fire     = valid_o32 && ready_i;
        last_in_fire = valid_i && ready_o32 && !flush_i;
        if (out_fire) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_beat", 64'(valid_o32), 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("imm32", 64'(imm_o32), 64'(e.exp32));
                checkOutput("tag32", 64'(tag_o32), 64'(e.tag));
                checkOutput("imm64", imm_o64, e.exp64);
            end
        end
        if (last_in_fire) sb.push_back(cur);
        @(posedge clk);
        #1;
        if (flush_i) sb.delete();
    endtask

    task automatic applyStimulus(input logic v, input imm_sel_e s,
                                 input logic [31:0] ins, input logic z,
                                 input logic [31:0] tg, input logic [31:0] e32,
                                 input logic [63:0] e64, input logic fl);
        valid_i    = v;
        sel_i      = s;
        instr_i    = ins;
        csr_zimm_i = z;
        tag_i      = tg;
        flush_i    = fl;
        cur.exp32  = e32;
        cur.exp64  = e64;
        cur.tag    = tg;
        cycle();
    endtask

    task automatic idle();
        applyStimulus(1'b0, IMM_R, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit tag3_pending;
        total_checks  = 0;
        passed_checks = 0;

        vectors[0] = '{IMM_I, 32'hFFF00093, 1'b0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        vectors[1] = '{IMM_S, 32'hFE112E23, 1'b0, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
        vectors[2] = '{IMM_B, 32'h00000863, 1'b0, 32'h00000010, 64'h0000000000000010};
        vectors[3] = '{IMM_U, 32'h123450B7, 1'b0, 32'h12345000, 64'h0000000012345000};
        vectors[4] = '{IMM_J, 32'hFFDFF06F, 1'b0, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
        vectors[5] = '{IMM_R, 32'hFFFFFFFF, 1'b0, 32'h00000000, 64'h0000000000000000};
        vectors[6] = '{IMM_U, 32'h800000B7, 1'b0, 32'h80000000, 64'hFFFFFFFF80000000};
        vectors[7] = '{IMM_I, 32'h000FD073, 1'b1, 32'h0000001F, 64'h000000000000001F};
        vectors[8] = '{IMM_B, 32'hFE000EE3, 1'b0, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};

        // Reset state, observed while reset is held.
        rst = 1'b1; valid_i = 1'b0; instr_i = '0; sel_i = IMM_R;
        csr_zimm_i = 1'b0; tag_i = '0; flush_i = 1'b0; ready_i = 1'b1;
        #12;
        checkOutput("reset_valid", 64'(valid_o32), 64'd0);
        checkOutput("reset_imm", 64'(imm_o32), 64'd0);
        checkOutput("reset_tag", 64'(tag_o32), 64'd0);
        checkOutput("reset_err", 64'(err_o32), 64'd0);
        checkOutput("reset_ready", 64'(ready_o32), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Format table, one beat per cycle, one-cycle latency.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, vectors[i].sel, vectors[i].instr, vectors[i].zimm,
                          32'(100 + i), vectors[i].exp32, vectors[i].exp64, 1'b0);
            checkOutput("latency_valid", 64'(valid_o32), 64'd1);
            checkOutput("latency_tag", 64'(tag_o32), 64'(100 + i));
        end
        idle();
        checkOutput("err_clean", 64'(err_o32), 64'd0);

        // Backpressure: tag 1 in main, tag 2 in skid, tag 3 waits upstream.
        ready_i = 1'b0;
        applyStimulus(1'b1, IMM_I, 32'h00100093, 1'b0, 32'd1, 32'd1, 64'd1, 1'b0);
        checkOutput("bp_ready_after_1", 64'(ready_o32), 64'd1);
        applyStimulus(1'b1, IMM_I, 32'h00200093, 1'b0, 32'd2, 32'd2, 64'd2, 1'b0);
        checkOutput("bp_ready_after_2", 64'(ready_o32), 64'd0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, IMM_I, 32'h00300093, 1'b0, 32'd3, 32'd3, 64'd3, 1'b0);
            checkOutput("bp_hold_tag", 64'(tag_o32), 64'd1);
            checkOutput("bp_hold_imm", 64'(imm_o32), 64'd1);
            checkOutput("bp_hold_ready", 64'(ready_o32), 64'd0);
        end
        ready_i = 1'b1;
        tag3_pending = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("bp_no_gap", 64'(valid_o32), 64'd1);
            if (tag3_pending) begin
                applyStimulus(1'b1, IMM_I, 32'h00300093, 1'b0, 32'd3, 32'd3, 64'd3, 1'b0);
                if (last_in_fire) tag3_pending = 1'b0;
            end else begin
                idle();
            end
        end
        checkOutput("bp_tag3_accepted", 64'(tag3_pending), 64'd0);
        checkOutput("bp_drained", 64'(valid_o32), 64'd0);

        // Flush with both entries full and a beat (tag 9) presented.
        ready_i = 1'b0;
        applyStimulus(1'b1, IMM_I, 32'h00500093, 1'b0, 32'd5, 32'd5, 64'd5, 1'b0);
        applyStimulus(1'b1, IMM_I, 32'h00600093, 1'b0, 32'd6, 32'd6, 64'd6, 1'b0);
        checkOutput("flush_setup_full", 64'(ready_o32), 64'd0);
        applyStimulus(1'b1, IMM_I, 32'h00900093, 1'b0, 32'd9, 32'd9, 64'd9, 1'b1);
        checkOutput("flush_valid", 64'(valid_o32), 64'd0);
        checkOutput("flush_ready", 64'(ready_o32), 64'd1);
        ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            idle();
            checkOutput("flush_stays_empty", 64'(valid_o32), 64'd0);
        end

        // Flush while ready_o=1: the concurrent beat (tag 11) must not land.
        applyStimulus(1'b1, IMM_I, 32'h00A00093, 1'b0, 32'd10, 32'd10, 64'd10, 1'b0);
        applyStimulus(1'b1, IMM_I, 32'h00B00093, 1'b0, 32'd11, 32'd11, 64'd11, 1'b1);
        checkOutput("flush2_valid", 64'(valid_o32), 64'd0);
        idle();
        checkOutput("flush2_stays_empty", 64'(valid_o32), 64'd0);

        // Undefined select: sticky error, zero immediate, survives flush.
        applyStimulus(1'b1, imm_sel_e'(3'd6), 32'hFFFFFFFF, 1'b0, 32'd40,
                      32'd0, 64'd0, 1'b0);
        checkOutput("err_set32", 64'(err_o32), 64'd1);
        checkOutput("err_set64", 64'(err_o64), 64'd1);
        idle();
        applyStimulus(1'b0, IMM_R, 32'h0, 1'b0, 32'd0, 32'd0, 64'd0, 1'b1);
        checkOutput("err_after_flush", 64'(err_o32), 64'd1);
        idle();

        // Asynchronous reset between edges with both entries full.
        ready_i = 1'b0;
        applyStimulus(1'b1, IMM_I, 32'h01400093, 1'b0, 32'd20, 32'd20, 64'd20, 1'b0);
        applyStimulus(1'b1, IMM_I, 32'h01500093, 1'b0, 32'd21, 32'd21, 64'd21, 1'b0);
        checkOutput("rst_setup_full", 64'(ready_o32), 64'd0);
        valid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 64'(valid_o32), 64'd0);
        checkOutput("async_rst_imm", 64'(imm_o32), 64'd0);
        checkOutput("async_rst_imm64", imm_o64, 64'd0);
        checkOutput("async_rst_tag", 64'(tag_o32), 64'd0);
        checkOutput("async_rst_ready", 64'(ready_o32), 64'd1);
        checkOutput("async_rst_err", 64'(err_o32), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        ready_i = 1'b1;
        applyStimulus(1'b1, IMM_U, 32'h123450B7, 1'b0, 32'd30,
                      32'h12345000, 64'h0000000012345000, 1'b0);
        checkOutput("post_rst_valid", 64'(valid_o32), 64'd1);
        checkOutput("post_rst_tag", 64'(tag_o32), 64'd30);
        idle();
        idle();

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised successor to the decode-stage immediate selector.
- Extracts, selects and sign-extends the immediate directly from the raw instruction word for a configurable XLEN, with optional CSR zimm support.
- Registers the result behind a valid/ready interface with a 2-entry skid buffer.
- Sits between the decoder and the ID/EX register.
- Supports stall (backpressure), flush and a sticky illegal-select flag.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
TAG_W, 32, width of sideband tag (typically PC) carried alongside the immediate.
ZIMM_EN, 1, 1 = honour csr_zimm_i; 0 = csr_zimm_i ignored.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
valid_i  input  1  upstream beat valid.
ready_o  output  1  block can accept a beat.
instr_i  input  32  raw instruction.
ImmSel_i  input  imm_sel_e  immediate format (R/I/S/B/U/J).
csr_zimm_i  input  1  select 5-bit CSR zimm (instr[19:15]) instead of ImmSel_i.
tag_i  input  TAG_W  sideband tag.
flush_i  input  1  synchronous pipeline flush.
valid_o  output  1  output beat valid.
ready_i  input  1  downstream accepts beat.
imm_o  output  XLEN  selected, extended immediate.
tag_o  output  TAG_W  tag matching imm_o.
err_o  output  1  sticky: an accepted beat carried an out-of-range ImmSel_i.

Behaviour:
- Extraction is combinational, sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25],instr[11:7]}.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
  - U: {instr[31:12],12'b0}, sign-extended to XLEN.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}.
  - R and any undefined encoding: 0.
- csr_zimm_i=1 with ZIMM_EN=1: zero-extended instr[19:15]; overrides ImmSel_i and does not set err_o.
- Transfer in: valid_i & ready_o. Transfer out: valid_o & ready_i.
- Storage: main register (drives outputs) plus one skid register; each entry holds {imm, tag, valid}.
- ready_o = ~skid_valid. This is purely registered state; there is no combinational path from ready_i.
- Latency: an accepted beat appears on imm_o/valid_o on the next rising edge when main is empty or draining. Throughput is 1 beat/cycle with ready_i held high.
- Main empty, or main draining this cycle: an incoming beat loads main. If skid is valid, skid moves to main and the incoming beat cannot arrive, because ready_o=0.
- Main full and not draining, incoming beat: beat loads skid and ready_o falls next cycle.
- Ordering is strictly FIFO; no beat is ever dropped or duplicated.
- flush_i=1: main_valid and skid_valid clear on that edge. A beat presented in the same cycle is discarded, since flush has priority. Data fields may retain stale values. Next cycle: valid_o=0, ready_o=1.
- err_o sets on acceptance of a beat whose ImmSel_i is outside the defined enum values. It is cleared only by rst, not by flush.
- Reset (asynchronous, any time, including mid-transfer): valid_o=0, imm_o=0, tag_o=0, err_o=0, skid empty, so ready_o=1. Beats presented while rst=1 are lost. The first accept occurs on the first edge after rst deasserts.
- Registered outputs are stable while valid_o=1 and ready_i=0.

Test Plan:
- Format check (XLEN=32, ready_i=1), one beat per cycle; each result must appear one cycle after its beat:
  - I 0xFFF00093 -> imm_o=0xFFFFFFFF.
  - S 0xFE112E23 -> 0xFFFFFFFC.
  - B 0x00000863 -> 0x00000010.
  - U 0x123450B7 -> 0x12345000.
  - J 0xFFDFF06F -> 0xFFFFFFFC.
  - R with any instr -> 0x00000000.
- XLEN=64:
  - U 0x800000B7 -> 0xFFFFFFFF80000000.
  - ZIMM_EN=1, csr_zimm_i=1, instr 0x000FD073 -> 0x000000000000001F.
- Backpressure:
  - Setup: ready_i=0; send tags 1,2,3 back-to-back.
  - Tag 1 holds in main and tag 2 goes to skid. ready_o=0 the cycle after tag 2, so tag 3 waits upstream.
  - Raise ready_i: tags 1,2,3 must emerge on consecutive cycles in order, with no gaps after the first.
- Flush: with main and skid full, assert flush_i with valid_i=1 (tag 9) -> next cycle valid_o=0, ready_o=1. Tag 9 never appears.
- Error flag:
  - Force an ImmSel_i value beyond J and accept the beat -> err_o=1 next cycle and imm_o=0.
  - err_o stays 1 through flush and clears only on rst.
- Reset mid-operation: assert rst asynchronously between edges with both entries full -> valid_o, imm_o and tag_o go to 0 immediately, ready_o=1. After release, a new beat flows with 1-cycle latency.
